div32_seq: RTL and testbench

Sequential signed 32/32 divider: the inverse counterpart to the team's combinational Booth multiplier, sharing its two's-complement operand conventions. It accepts a dividend and divisor on a start pulse, runs one restoring-division step per clock over 32 cycles, and returns a truncated quotient and remainder with a one-cycle done pulse. It sits beside the multiplier in the arithmetic unit and serves division/modulo operations that tolerate multi-cycle latency.

---
 rtl/div_pkg.sv | 10 +
 rtl/div_step.sv | 19 +
 rtl/div32_seq.sv | 95 +++++++++
 tb/tb_div32_seq.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// div_pkg: shared types and constants for the sequential signed divider
package div_pkg;
  localparam int DIV_WIDTH = 32;
  localparam int DIV_STEPS = 32;
  localparam logic [DIV_WIDTH-1:0] DIV0_QUOTIENT = '1;
  typedef enum logic [1:0] {IDLE, CALC, SIGN} div_state_t;
  function automatic logic [DIV_WIDTH-1:0] abs_val(input logic [DIV_WIDTH-1:0] x);
    return x[DIV_WIDTH-1] ? -x : x;
  endfunction
endpackage

// File: rtl/div_step.sv
// div_step: one combinational restoring-division step
module div_step
  import div_pkg::*;
(
  input  logic [DIV_WIDTH-1:0] i_r,
  input  logic                 i_q_msb,
  input  logic [DIV_WIDTH-1:0] i_d,
  output logic [DIV_WIDTH-1:0] o_r,
  output logic                 o_q_bit
);
  logic [DIV_WIDTH:0] w_shift;
  logic [DIV_WIDTH:0] w_trial;
  always_comb begin
    w_shift = {i_r, i_q_msb};
    w_trial = w_shift - {1'b0, i_d};
    o_q_bit = ~w_trial[DIV_WIDTH];
    o_r     = o_q_bit ? w_trial[DIV_WIDTH-1:0] : w_shift[DIV_WIDTH-1:0];
  end
endmodule

// File: rtl/div32_seq.sv
// div32_seq: 32-cycle signed restoring divider with truncated quotient/remainder
module div32_seq
  import div_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 i_start,
  input  logic [DIV_WIDTH-1:0] i_dividend,
  input  logic [DIV_WIDTH-1:0] i_divisor,
  output logic                 o_busy,
  output logic                 o_done,
  output logic [DIV_WIDTH-1:0] o_quotient,
  output logic [DIV_WIDTH-1:0] o_remainder,
  output logic                 o_div_zero
);
  div_state_t r_state, w_next;
  logic [5:0]           r_cnt;
  logic [DIV_WIDTH-1:0] r_q, r_r, r_d, r_quot, r_rem;
  logic                 r_sq, r_sr, r_busy, r_done, r_dz, r_pend;
  logic [DIV_WIDTH-1:0] w_r;
  logic                 w_q_bit;
  logic                 w_accept;
  div_step u_step (
    .i_r     (r_r),
    .i_q_msb (r_q[DIV_WIDTH-1]),
    .i_d     (r_d),
    .o_r     (w_r),
    .o_q_bit (w_q_bit)
  );
  always_comb begin
    w_accept = (r_state == IDLE) && i_start;
    w_next   = r_state == IDLE ? ((w_accept && i_divisor != '0) ? CALC : IDLE) :
               r_state == CALC ? ((r_cnt == 6'(DIV_STEPS - 1)) ? SIGN : CALC) : IDLE;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt  <= '0;
      r_q    <= '0;
      r_r    <= '0;
      r_d    <= '0;
      r_quot <= '0;
      r_rem  <= '0;
      r_sq   <= 1'b0;
      r_sr   <= 1'b0;
      r_busy <= 1'b0;
      r_done <= 1'b0;
      r_dz   <= 1'b0;
      r_pend <= 1'b0;
    end else begin
      r_done <= 1'b0;
      // divide-by-zero result lands one edge after acceptance, raw dividend parked in r_q
      if (r_pend) begin
        r_quot <= DIV0_QUOTIENT;
        r_rem  <= r_q;
        r_dz   <= 1'b1;
        r_done <= 1'b1;
        r_pend <= 1'b0;
      end
      if (w_accept) begin
        if (i_divisor == '0) begin
          r_pend <= 1'b1;
          r_q    <= i_dividend;
        end else begin
          r_q    <= abs_val(i_dividend);
          r_d    <= abs_val(i_divisor);
          r_sq   <= i_dividend[DIV_WIDTH-1] ^ i_divisor[DIV_WIDTH-1];
          r_sr   <= i_dividend[DIV_WIDTH-1];
          r_r    <= '0;
          r_cnt  <= '0;
          r_busy <= 1'b1;
        end
      end
      if (r_state == CALC) begin
        r_r   <= w_r;
        r_q   <= {r_q[DIV_WIDTH-2:0], w_q_bit};
        r_cnt <= r_cnt + 6'd1;
      end
      if (r_state == SIGN) begin
        r_quot <= r_sq ? -r_q : r_q;
        r_rem  <= r_sr ? -r_r : r_r;
        r_dz   <= 1'b0;
        r_done <= 1'b1;
        r_busy <= 1'b0;
      end
    end
  end
  assign o_busy      = r_busy;
  assign o_done      = r_done;
  assign o_quotient  = r_quot;
  assign o_remainder = r_rem;
  assign o_div_zero  = r_dz;
endmodule

// File: tb/tb_div32_seq.sv
// tb_div32_seq: scoreboard bench for div32_seq against a 64-bit arithmetic model
module tb_div32_seq;
  typedef struct packed {
    logic [31:0] q;
    logic [31:0] r;
    logic        dz;
  } exp_t;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        i_start = 1'b0;
  logic [31:0] i_dividend = '0;
  logic [31:0] i_divisor = '0;
  logic        o_busy, o_done, o_div_zero;
  logic [31:0] o_quotient, o_remainder;
  exp_t        sb[$];
  int          n_tests = 0;
  int          n_fail = 0;
  int          n_done = 0;
  int          n_issued = 0;
  div32_seq dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_start     (i_start),
    .i_dividend  (i_dividend),
    .i_divisor   (i_divisor),
    .o_busy      (o_busy),
    .o_done      (o_done),
    .o_quotient  (o_quotient),
    .o_remainder (o_remainder),
    .o_div_zero  (o_div_zero)
  );
  always #5 clk = ~clk;
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  function automatic exp_t model(input logic [31:0] a, input logic [31:0] b);
    longint sa, sd, q, r;
    exp_t e;
    if (b == 32'd0) begin
      e = '{q: 32'hFFFF_FFFF, r: a, dz: 1'b1};
      return e;
    end
    sa = longint'($signed(a));
    sd = longint'($signed(b));
    q = sa / sd;
    r = sa % sd;
    e = '{q: q[31:0], r: r[31:0], dz: 1'b0};
    return e;
  endfunction
  always @(negedge clk) begin
    if (rst_n && o_done) begin
      exp_t e;
      n_done++;
      if (sb.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_done: got done with q=%h r=%h, required no done", o_quotient, o_remainder);
      end else begin
        e = sb.pop_front();
        check("quotient", o_quotient, e.q);
        check("remainder", o_remainder, e.r);
        check("div_zero", 32'(o_div_zero), 32'(e.dz));
      end
    end
  end
  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input exp_t e,
                        input int exp_lat, input bit timing);
    int lat, bc;
    i_dividend = a;
    i_divisor  = b;
    i_start    = 1'b1;
    sb.push_back(e);
    n_issued++;
    @(posedge clk); #1;
    i_start    = 1'b0;
    i_dividend = $urandom;
    i_divisor  = $urandom;
    lat = 0;
    bc  = 0;
    while (!o_done && lat < 100) begin
      if (o_busy) bc++;
      @(posedge clk); #1;
      lat++;
    end
    if (timing || lat >= 100) begin
      check("latency", 32'(lat), 32'(exp_lat));
      check("busy_cycles", 32'(bc), 32'(exp_lat == 1 ? 0 : exp_lat));
    end
    if (timing) check("busy_at_done", 32'(o_busy), 32'd0);
  endtask
  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish in time");
    $fatal(1, "timeout");
  end
  initial begin
    logic [31:0] a, b;
    int lat;
    repeat (3) @(posedge clk);
    #1;
    check("rst_quotient", o_quotient, 32'd0);
    check("rst_remainder", o_remainder, 32'd0);
    check("rst_busy", 32'(o_busy), 32'd0);
    check("rst_done", 32'(o_done), 32'd0);
    check("rst_div_zero", 32'(o_div_zero), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    run_op(32'd100, 32'd7, '{q: 32'd14, r: 32'd2, dz: 1'b0}, 33, 1'b1);
    run_op(-32'sd100, 32'd7, '{q: 32'hFFFF_FFF2, r: 32'hFFFF_FFFE, dz: 1'b0}, 33, 1'b1);
    run_op(32'd100, -32'sd7, '{q: 32'hFFFF_FFF2, r: 32'd2, dz: 1'b0}, 33, 1'b1);
    run_op(32'h8000_0000, 32'hFFFF_FFFF, '{q: 32'h8000_0000, r: 32'd0, dz: 1'b0}, 33, 1'b1);
    run_op(32'h8000_0000, 32'd1, '{q: 32'h8000_0000, r: 32'd0, dz: 1'b0}, 33, 1'b1);
    run_op(32'd5, 32'd0, '{q: 32'hFFFF_FFFF, r: 32'd5, dz: 1'b1}, 1, 1'b1);
    run_op(32'd9, 32'd3, '{q: 32'd3, r: 32'd0, dz: 1'b0}, 33, 1'b1);
    // a start pulse mid-operation must not disturb the captured operands
    i_dividend = 32'd1000;
    i_divisor  = 32'd3;
    i_start    = 1'b1;
    sb.push_back('{q: 32'd333, r: 32'd1, dz: 1'b0});
    n_issued++;
    @(posedge clk); #1;
    i_start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    i_dividend = 32'd7;
    i_divisor  = 32'd7;
    i_start    = 1'b1;
    @(posedge clk); #1;
    i_start = 1'b0;
    check("busy_midop", 32'(o_busy), 32'd1);
    lat = 0;
    while (!o_done && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    check("ignored_start_latency", 32'(lat), 32'd28);
    // reset mid-operation: outputs clear asynchronously and the op is dropped
    i_dividend = 32'd12345;
    i_divisor  = 32'd17;
    i_start    = 1'b1;
    @(posedge clk); #1;
    i_start = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("midrst_quotient", o_quotient, 32'd0);
    check("midrst_remainder", o_remainder, 32'd0);
    check("midrst_busy", 32'(o_busy), 32'd0);
    check("midrst_done", 32'(o_done), 32'd0);
    check("midrst_div_zero", 32'(o_div_zero), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (40) @(posedge clk);
    #1;
    check("no_done_after_rst", 32'(n_done), 32'(n_issued));
    run_op(-32'sd7, 32'd2, '{q: 32'hFFFF_FFFD, r: 32'hFFFF_FFFF, dz: 1'b0}, 33, 1'b1);
    // back-to-back random traffic, each start issued in the previous done cycle
    for (int i = 0; i < 1500; i++) begin
      a = $urandom;
      case ($urandom_range(0, 15))
        0:       b = 32'd0;
        1:       b = 32'hFFFF_FFFF;
        2, 3, 4: b = 32'($signed($urandom_range(0, 40)) - 20);
        default: b = $urandom;
      endcase
      if ($urandom_range(0, 31) == 0) a = 32'h8000_0000;
      run_op(a, b, model(a, b), (b == 32'd0) ? 1 : 33, 1'b0);
    end
    repeat (3) @(posedge clk);
    #1;
    check("done_count", 32'(n_done), 32'(n_issued));
    check("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
